// File: rtl/led_pwm_fader.sv
// led_pwm_fader: ramps each of 8 LED PWM duties toward an on/off pattern target.
// Define LED_PWM_FADER_GAMMA_EN for a squared (perceptual) level-to-duty curve.
module led_pwm_fader #(
  parameter int PRESCALE  = 195,
  parameter int FADE_STEP = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] pattern_in,
  input  logic       pattern_valid,
  input  logic       enable,
  output logic [7:0] led_out,
  output logic       fade_busy
);
  localparam int PW = PRESCALE > 1 ? $clog2(PRESCALE) : 1;
  localparam logic [PW-1:0] PLAST = PW'(PRESCALE - 1);
  localparam logic [8:0] STEP = 9'(FADE_STEP);
  logic [PW-1:0] presc_cnt;
  logic [7:0] pwm_cnt, target, led_nxt, busy_vec;
  logic [7:0][7:0] level, level_nxt, duty;
  logic tick, period_end;
  assign tick = presc_cnt == PLAST;
  assign period_end = tick && pwm_cnt == 8'hff;
  for (genvar i = 0; i < 8; i++) begin : g_ch
    logic [8:0] up, dn;
    assign up = {1'b0, level[i]} + STEP;
    assign dn = {1'b0, level[i]} - STEP;
    // Saturation makes the idle cases (255 going up, 0 going down) hold naturally
    assign level_nxt[i] = !period_end ? level[i] :
                          target[i]   ? (up[8] ? 8'hff : up[7:0]) :
                                        (dn[8] ? 8'h00 : dn[7:0]);
`ifdef LED_PWM_FADER_GAMMA_EN
    logic [15:0] sq;
    assign sq = {8'h00, level[i]} * {8'h00, level[i]};
    assign duty[i] = level[i] == 8'hff ? 8'hff : sq[15:8];
`else
    assign duty[i] = level[i];
`endif
    assign led_nxt[i] = enable && (duty[i] == 8'hff || pwm_cnt < duty[i]);
    assign busy_vec[i] = level[i] != {8{target[i]}};
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      presc_cnt <= '0;
      pwm_cnt   <= '0;
      target    <= '0;
      level     <= '0;
      led_out   <= '0;
      fade_busy <= 1'b0;
    end else begin
      presc_cnt <= tick ? '0 : presc_cnt + PW'(1);
      pwm_cnt   <= pwm_cnt + 8'(tick);
      target    <= pattern_valid ? pattern_in : target;
      level     <= level_nxt;
      led_out   <= led_nxt;
      fade_busy <= |busy_vec;
    end
  end
endmodule

// File: tb/tb_led_pwm_fader.sv
// tb_led_pwm_fader: directed checks of fading, reversal, enable and reset with PRESCALE=1, FADE_STEP=64.
module tb_led_pwm_fader;
`ifdef LED_PWM_FADER_GAMMA_EN
  localparam int D64 = 16, D128 = 64, D191 = 142, D63 = 15;
`else
  localparam int D64 = 64, D128 = 128, D191 = 191, D63 = 63;
`endif
  logic clk = 1'b0, rst = 1'b1, pattern_valid = 1'b0, enable = 1'b1;
  logic [7:0] pattern_in = '0, led_out;
  logic fade_busy;
  int cyc, checks = 0, failures = 0;

  typedef struct {
    int at;
    logic en, valid;
    logic [7:0] pat, led;
    logic busy;
  } vec_t;
  vec_t vecs[$];

  led_pwm_fader #(.PRESCALE(1), .FADE_STEP(64)) dut (
    .clk(clk), .rst(rst), .pattern_in(pattern_in), .pattern_valid(pattern_valid),
    .enable(enable), .led_out(led_out), .fade_busy(fade_busy)
  );

  always #5 clk = ~clk;
  // Cycles since reset release; with PRESCALE=1 pwm_cnt == cyc % 256 at each negedge
  always @(posedge clk or posedge rst) cyc <= rst ? 0 : cyc + 1;

  task automatic chk(input string name, input logic [7:0] led, input logic busy);
    checks++;
    if (led_out !== led || fade_busy !== busy) begin
      failures++;
      $display("FAIL %s cyc=%0d led_out=%h fade_busy=%b expected led_out=%h fade_busy=%b",
               name, cyc, led_out, fade_busy, led, busy);
    end
  endtask

  task automatic at(input int t);
    while (cyc < t) @(negedge clk);
    if (cyc != t) begin
      checks++;
      failures++;
      $display("FAIL schedule cyc=%0d expected cyc=%0d", cyc, t);
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    pattern_valid = 1'b0;
    enable = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic strobe(input int t, input logic [7:0] p);
    at(t);
    pattern_in = p;
    pattern_valid = 1'b1;
    at(t + 1);
    pattern_valid = 1'b0;
  endtask

  task automatic run_vecs(input string name);
    foreach (vecs[k]) begin
      at(vecs[k].at);
      chk($sformatf("%s[%0d]", name, k), vecs[k].led, vecs[k].busy);
      enable = vecs[k].en;
      pattern_valid = vecs[k].valid;
      pattern_in = vecs[k].pat;
    end
    pattern_valid = 1'b0;
  endtask

  initial begin
    do_reset();
    vecs = '{
      '{0,    1, 1, 8'h01, 8'h00, 0},
      '{1,    1, 0, 8'h00, 8'h00, 0},
      '{2,    1, 0, 8'h00, 8'h00, 1},
      '{256,  1, 0, 8'h00, 8'h00, 1},
      '{257,  1, 0, 8'h00, 8'h01, 1},
      '{256 + D64, 1, 0, 8'h00, 8'h01, 1},
      '{257 + D64, 1, 0, 8'h00, 8'h00, 1},
      '{513,  1, 0, 8'h00, 8'h01, 1},
      '{512 + D128, 1, 0, 8'h00, 8'h01, 1},
      '{513 + D128, 1, 0, 8'h00, 8'h00, 1},
      '{1024, 1, 0, 8'h00, 8'h00, 1},
      '{1025, 1, 0, 8'h00, 8'h01, 0},
      '{1100, 1, 0, 8'h00, 8'h01, 0}
    };
    run_vecs("fade_up");

    do_reset();
    vecs = '{
      '{0,    1, 1, 8'hff, 8'h00, 0},
      '{1,    1, 0, 8'h00, 8'h00, 0},
      '{1025, 1, 1, 8'h00, 8'hff, 0},
      '{1026, 1, 0, 8'h00, 8'hff, 0},
      '{1027, 1, 0, 8'h00, 8'hff, 1},
      '{1280 + D191, 1, 0, 8'h00, 8'hff, 1},
      '{1281 + D191, 1, 0, 8'h00, 8'h00, 1},
      '{1792 + D63, 1, 0, 8'h00, 8'hff, 1},
      '{1793 + D63, 1, 0, 8'h00, 8'h00, 1},
      '{2048, 1, 0, 8'h00, 8'h00, 1},
      '{2049, 1, 0, 8'h00, 8'h00, 0},
      '{2200, 1, 0, 8'h00, 8'h00, 0}
    };
    run_vecs("fade_down");

    // Reversal mid-fade, then a strobe landing exactly on a period_end
    do_reset();
    strobe(0, 8'h01);
    at(600);
    chk("rev_l128", 8'h01, 1'b1);
    strobe(600, 8'h00);
    at(768 + D64);
    chk("rev_l64_on", 8'h01, 1'b1);
    at(769 + D64);
    chk("rev_l64_off", 8'h00, 1'b1);
    at(1024);
    chk("rev_busy_tail", 8'h00, 1'b1);
    at(1025);
    chk("rev_done", 8'h00, 1'b0);
    strobe(1279, 8'h01);
    at(1281);
    chk("coincident_old_target", 8'h00, 1'b1);
    at(1537);
    chk("coincident_next_period", 8'h01, 1'b1);

    // Enable gating while levels keep fading underneath
    at(2310);
    chk("en_full_on", 8'h01, 1'b0);
    enable = 1'b0;
    at(2311);
    chk("en_off_next", 8'h00, 1'b0);
    strobe(2320, 8'h00);
    at(2600);
    chk("en_off_fading", 8'h00, 1'b1);
    enable = 1'b1;
    at(2601);
    chk("en_resume", 8'h01, 1'b1);
    at(2560 + D191);
    chk("en_l191_on", 8'h01, 1'b1);
    at(2561 + D191);
    chk("en_l191_off", 8'h00, 1'b1);

    // Asynchronous reset mid-fade
    do_reset();
    strobe(0, 8'h01);
    at(600);
    chk("pre_rst", 8'h01, 1'b1);
    #1 rst = 1'b1;
    #1 chk("rst_async", 8'h00, 1'b0);
    @(negedge clk);
    rst = 1'b0;
    chk("post_rst", 8'h00, 1'b0);
    strobe(0, 8'h01);
    at(256);
    chk("restart_l0", 8'h00, 1'b1);
    at(257);
    chk("restart_l64", 8'h01, 1'b1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
